// File: rtl/register_file.sv
// 32 x 16-bit register file with two bypassed read ports, two write ports
// and a per-register pending-write scoreboard for decode hazard checks.
module register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_addr_0,
    input  logic [ADDR_W-1:0] src_addr_1,
    output logic [DATA_W-1:0] src_data_0,
    output logic [DATA_W-1:0] src_data_1,
    output logic              src_hazard_0,
    output logic              src_hazard_1,
    input  logic              issue_valid,
    input  logic              issue_we_0,
    input  logic [ADDR_W-1:0] issue_addr_0,
    input  logic              issue_we_1,
    input  logic [ADDR_W-1:0] issue_addr_1,
    output logic              issue_stall,
    input  logic              dst_we_0,
    input  logic [ADDR_W-1:0] dst_addr_0,
    input  logic [DATA_W-1:0] reg_0_wrt_data,
    input  logic              dst_we_1,
    input  logic [ADDR_W-1:0] dst_addr_1,
    input  logic [DATA_W-1:0] reg_1_wrt_data,
    output logic              sb_err
);

    // Counter math is done two bits wider so +2 and -2 never wrap.
    localparam int CW = PEND_W + 2;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic signed [CW-1:0] CMAX = CW'((2 ** PEND_W) - 1);

    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [PEND_W-1:0] cnt     [NUM_REGS];
    logic [PEND_W-1:0] cnt_nxt [NUM_REGS];
    logic              err_nxt;
    logic              stall;

    function automatic logic [CW-1:0] wb_hits(input logic [ADDR_W-1:0] a);
        logic [CW-1:0] n;
        n = '0;
        if (dst_we_0 && dst_addr_0 == a) n = n + ONE;
        if (dst_we_1 && dst_addr_1 == a) n = n + ONE;
        return n;
    endfunction

    function automatic logic [CW-1:0] iss_hits(input logic [ADDR_W-1:0] a);
        logic [CW-1:0] n;
        n = '0;
        if (issue_valid && issue_we_0 && issue_addr_0 == a) n = n + ONE;
        if (issue_valid && issue_we_1 && issue_addr_1 == a) n = n + ONE;
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        if (dst_we_1 && dst_addr_1 == a)
            d = reg_1_wrt_data;
        else if (dst_we_0 && dst_addr_0 == a)
            d = reg_0_wrt_data;
        else
            d = regs[a];
        return d;
    endfunction

    // Read ports: bypass in-flight writebacks; a hazard remains only if more
    // writes are outstanding than are being satisfied this cycle.
    always_comb begin
        src_data_0   = rst ? '0 : rd(src_addr_0);
        src_data_1   = rst ? '0 : rd(src_addr_1);
        src_hazard_0 = !rst && ({2'b00, cnt[src_addr_0]} > wb_hits(src_addr_0));
        src_hazard_1 = !rst && ({2'b00, cnt[src_addr_1]} > wb_hits(src_addr_1));
    end

    // Stall if any requested destination would exceed the in-flight limit.
    always_comb begin : stall_calc
        logic [CW-1:0] req;
        logic signed [CW-1:0] t;
        stall = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            req = iss_hits(ADDR_W'(r));
            t = $signed({2'b00, cnt[r]}) + $signed(req)
                - $signed(wb_hits(ADDR_W'(r)));
            if (req != '0 && t > CMAX) stall = 1'b1;
        end
        issue_stall = stall && !rst;
    end

    // Next scoreboard counts; underflow clamps to zero and flags an error.
    always_comb begin : cnt_calc
        logic [CW-1:0] inc;
        logic signed [CW-1:0] t;
        err_nxt = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc = stall ? '0 : iss_hits(ADDR_W'(r));
            t = $signed({2'b00, cnt[r]}) + $signed(inc)
                - $signed(wb_hits(ADDR_W'(r)));
            if (t[CW-1]) begin
                cnt_nxt[r] = '0;
                err_nxt    = 1'b1;
            end else begin
                cnt_nxt[r] = t[PEND_W-1:0];
            end
        end
    end

    // Register array, counters and sticky error; port 1 wins on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (dst_we_0) regs[dst_addr_0] <= reg_0_wrt_data;
            if (dst_we_1) regs[dst_addr_1] <= reg_1_wrt_data;
            cnt <= cnt_nxt;
            if (err_nxt) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus randomized traffic
// checked against an integer-based reference model.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  src_addr_0, src_addr_1;
    logic [15:0] src_data_0, src_data_1;
    logic        src_hazard_0, src_hazard_1;
    logic        issue_valid, issue_we_0, issue_we_1;
    logic [4:0]  issue_addr_0, issue_addr_1;
    logic        issue_stall;
    logic        dst_we_0, dst_we_1;
    logic [4:0]  dst_addr_0, dst_addr_1;
    logic [15:0] reg_0_wrt_data, reg_1_wrt_data;
    logic        sb_err;

    logic [15:0] mreg [32];
    int          mcnt [32];
    bit          merr;
    int          n_cmp;
    int          n_bad;

    register_file dut (
        .clk(clk), .rst(rst),
        .src_addr_0(src_addr_0), .src_addr_1(src_addr_1),
        .src_data_0(src_data_0), .src_data_1(src_data_1),
        .src_hazard_0(src_hazard_0), .src_hazard_1(src_hazard_1),
        .issue_valid(issue_valid),
        .issue_we_0(issue_we_0), .issue_addr_0(issue_addr_0),
        .issue_we_1(issue_we_1), .issue_addr_1(issue_addr_1),
        .issue_stall(issue_stall),
        .dst_we_0(dst_we_0), .dst_addr_0(dst_addr_0),
        .reg_0_wrt_data(reg_0_wrt_data),
        .dst_we_1(dst_we_1), .dst_addr_1(dst_addr_1),
        .reg_1_wrt_data(reg_1_wrt_data),
        .sb_err(sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nwb(input logic [4:0] a);
        return int'(dst_we_0 && dst_addr_0 == a) + int'(dst_we_1 && dst_addr_1 == a);
    endfunction

    function automatic int nis(input logic [4:0] a);
        if (!issue_valid) return 0;
        return int'(issue_we_0 && issue_addr_0 == a) + int'(issue_we_1 && issue_addr_1 == a);
    endfunction

    function automatic logic [15:0] m_rd(input logic [4:0] a);
        if (dst_we_1 && dst_addr_1 == a) return reg_1_wrt_data;
        if (dst_we_0 && dst_addr_0 == a) return reg_0_wrt_data;
        return mreg[a];
    endfunction

    function automatic bit m_stall();
        for (int r = 0; r < 32; r++)
            if (nis(5'(r)) > 0 && mcnt[r] + nis(5'(r)) - nwb(5'(r)) > 3) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mreg[r] = '0;
            mcnt[r] = 0;
        end
        merr = 1'b0;
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic tick();
        bit es;
        if (rst) model_clear();
        #1;
        es = rst ? 1'b0 : m_stall();
        check("rd0", 32'(src_data_0), rst ? 32'd0 : 32'(m_rd(src_addr_0)));
        check("rd1", 32'(src_data_1), rst ? 32'd0 : 32'(m_rd(src_addr_1)));
        check("hz0", 32'(src_hazard_0),
              32'(!rst && mcnt[src_addr_0] > nwb(src_addr_0)));
        check("hz1", 32'(src_hazard_1),
              32'(!rst && mcnt[src_addr_1] > nwb(src_addr_1)));
        check("stall", 32'(issue_stall), 32'(es));
        check("sb_err", 32'(sb_err), 32'(merr));
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int r = 0; r < 32; r++) begin
                int d;
                d = mcnt[r] + (es ? 0 : nis(5'(r))) - nwb(5'(r));
                if (d < 0) begin
                    d = 0;
                    merr = 1'b1;
                end
                mcnt[r] = d;
            end
            if (dst_we_0) mreg[dst_addr_0] = reg_0_wrt_data;
            if (dst_we_1) mreg[dst_addr_1] = reg_1_wrt_data;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_we_0 = 0; issue_we_1 = 0;
        issue_addr_0 = 0; issue_addr_1 = 0;
        dst_we_0 = 0; dst_we_1 = 0; dst_addr_0 = 0; dst_addr_1 = 0;
        reg_0_wrt_data = 0; reg_1_wrt_data = 0;
    endtask

    task automatic issue1(input logic [4:0] a);
        issue_valid = 1; issue_we_0 = 1; issue_addr_0 = a;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1;
        src_addr_0 = 0;
        src_addr_1 = 0;
        idle();
        model_clear();
        @(negedge clk);
        tick();
        rst = 0;

        for (int i = 0; i < 32; i++) begin
            src_addr_0 = 5'(i);
            src_addr_1 = 5'(i) ^ 5'h1F;
            #1 check("rst_rd0", 32'(src_data_0), 32'd0);
            tick();
        end

        // R5: reserve twice, write, read back, then bypass a new value
        issue_valid = 1; issue_we_0 = 1; issue_we_1 = 1;
        issue_addr_0 = 5; issue_addr_1 = 5;
        tick(); idle();
        dst_we_0 = 1; dst_addr_0 = 5; reg_0_wrt_data = 16'hBEEF;
        tick(); idle();
        src_addr_0 = 5;
        #1 check("r5_rd", 32'(src_data_0), 32'h0000_BEEF);
        tick();
        dst_we_0 = 1; dst_addr_0 = 5; reg_0_wrt_data = 16'h1234;
        #1 check("r5_byp", 32'(src_data_0), 32'h0000_1234);
        tick(); idle();

        // R7: both ports collide, port 1 wins
        issue_valid = 1; issue_we_0 = 1; issue_we_1 = 1;
        issue_addr_0 = 7; issue_addr_1 = 7;
        tick(); idle();
        dst_we_0 = 1; dst_addr_0 = 7; reg_0_wrt_data = 16'hAAAA;
        dst_we_1 = 1; dst_addr_1 = 7; reg_1_wrt_data = 16'h5555;
        src_addr_1 = 7;
        #1 check("r7_same", 32'(src_data_1), 32'h0000_5555);
        tick(); idle();
        src_addr_0 = 7;
        #1 check("r7_rd", 32'(src_data_0), 32'h0000_5555);
        tick();

        // R3: fill to the limit, stall, then issue against a writeback
        for (int i = 0; i < 3; i++) begin
            issue1(3);
            tick();
        end
        idle();
        src_addr_0 = 3;
        #1 check("r3_haz", 32'(src_hazard_0), 32'd1);
        tick();
        issue1(3);
        #1 check("r3_stall", 32'(issue_stall), 32'd1);
        tick();
        dst_we_0 = 1; dst_addr_0 = 3;
        #1 check("r3_nostall", 32'(issue_stall), 32'd0);
        tick(); idle();
        issue1(3);
        #1 check("r3_full", 32'(issue_stall), 32'd1);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            dst_we_0 = 1; dst_addr_0 = 3;
            tick();
        end
        idle();
        #1 check("r3_drain", 32'(src_hazard_0), 32'd0);
        check("r3_noerr", 32'(sb_err), 32'd0);
        tick();

        // R9: last outstanding write satisfied in the same cycle
        issue1(9);
        tick(); idle();
        dst_we_0 = 1; dst_addr_0 = 9; reg_0_wrt_data = 16'h9999;
        src_addr_1 = 9;
        #1 check("r9_hz", 32'(src_hazard_1), 32'd0);
        check("r9_byp", 32'(src_data_1), 32'h0000_9999);
        tick(); idle();
        #1 check("r9_clr", 32'(src_hazard_1), 32'd0);
        tick();

        // R12: writeback with nothing outstanding, then async reset
        dst_we_0 = 1; dst_addr_0 = 12; reg_0_wrt_data = 16'h0C0C;
        tick(); idle();
        src_addr_0 = 12;
        #1 check("r12_err", 32'(sb_err), 32'd1);
        check("r12_rd", 32'(src_data_0), 32'h0000_0C0C);
        tick();
        tick();
        #2 rst = 1;
        #1 check("arst_err", 32'(sb_err), 32'd0);
        check("arst_rd", 32'(src_data_0), 32'd0);
        tick();
        rst = 0;
        #1 check("r12_clr", 32'(src_data_0), 32'd0);
        tick();

        // Randomized traffic over a small address window to force collisions
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            issue_valid = $urandom_range(0, 9) < 6;
            issue_we_0 = $urandom_range(0, 1) == 1;
            issue_we_1 = $urandom_range(0, 2) == 0;
            issue_addr_0 = 5'($urandom_range(0, 7));
            issue_addr_1 = 5'($urandom_range(0, 7));
            dst_we_0 = $urandom_range(0, 2) == 0;
            dst_we_1 = $urandom_range(0, 3) == 0;
            dst_addr_0 = 5'($urandom_range(0, 7));
            dst_addr_1 = 5'($urandom_range(0, 7));
            reg_0_wrt_data = 16'($urandom);
            reg_1_wrt_data = 16'($urandom);
            src_addr_0 = 5'($urandom_range(0, 7));
            src_addr_1 = 5'($urandom_range(0, 31));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
